// File: rtl/rf_scoreboard.sv
// Register-file hazard scoreboard: per-register pending-write counters gate issue on RAW
// hazards and write/in-flight saturation; writeback retires, flush squashes everything.
module rf_scoreboard #(
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned MAX_INFL  = 4,
  parameter bit          WB_BYPASS = 1'b1,
  localparam int unsigned INFL_W   = $clog2(MAX_INFL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [4:0]        iss_rs1,
  input  logic              iss_rs1_en,
  input  logic [4:0]        iss_rs2,
  input  logic              iss_rs2_en,
  input  logic [4:0]        iss_rd,
  input  logic              iss_rd_we,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              flush,
  output logic [31:0]       pending,
  output logic [INFL_W-1:0] inflight,
  output logic              wb_err
);

  localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [INFL_W-1:0] InflMax = INFL_W'(MAX_INFL);
  localparam logic [INFL_W-1:0] InflOne = INFL_W'(1);

  // Entry 0 exists only so that x0 lookups read a constant zero.
  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [INFL_W-1:0] infl_q, infl_d;
  logic              wb_err_q, wb_err_d;

  logic wb_hit, retire, rd_act, alloc;
  logic rs1_haz, rs2_haz, rd_sat, infl_sat;

  always_comb begin
    wb_hit  = wb_valid && (wb_rd != 5'd0);
    retire  = wb_hit && (cnt_q[wb_rd] != '0);
    rd_act  = iss_rd_we && (iss_rd != 5'd0);

    // A last outstanding write retiring now is forwarded, so it is not a hazard.
    rs1_haz = iss_rs1_en && (iss_rs1 != 5'd0) && (cnt_q[iss_rs1] != '0) &&
              !(WB_BYPASS && (cnt_q[iss_rs1] == CntOne) && retire && (wb_rd == iss_rs1));
    rs2_haz = iss_rs2_en && (iss_rs2 != 5'd0) && (cnt_q[iss_rs2] != '0) &&
              !(WB_BYPASS && (cnt_q[iss_rs2] == CntOne) && retire && (wb_rd == iss_rs2));

    rd_sat   = rd_act && (cnt_q[iss_rd] == CntMax);
    infl_sat = rd_act && (infl_q == InflMax) && !retire;

    iss_ready = !flush && !rs1_haz && !rs2_haz && !rd_sat && !infl_sat;
    alloc     = iss_valid && iss_ready && rd_act;
  end

  always_comb begin
    logic up, dn;
    cnt_d    = cnt_q;
    infl_d   = infl_q;
    wb_err_d = wb_err_q;
    up       = 1'b0;
    dn       = 1'b0;
    if (flush) begin
      for (int r = 0; r < 32; r++) begin
        cnt_d[r] = '0;
      end
      infl_d = '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        up = alloc && (iss_rd == 5'(r));
        dn = retire && (wb_rd == 5'(r));
        if (up && !dn) begin
          cnt_d[r] = cnt_q[r] + CntOne;
        end else if (dn && !up) begin
          cnt_d[r] = cnt_q[r] - CntOne;
        end
      end
      if (alloc && !retire) begin
        infl_d = infl_q + InflOne;
      end else if (retire && !alloc) begin
        infl_d = infl_q - InflOne;
      end
      if (wb_hit && !retire) begin
        wb_err_d = 1'b1;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      infl_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
      wb_err_q <= wb_err_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 1; r < 32; r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
  end

  assign inflight = infl_q;
  assign wb_err   = wb_err_q;

  infl_bound_a : assert property (@(posedge clk) disable iff (reset) infl_q <= InflMax);

endmodule
